// File: rtl/dffram_pkg.sv
// dffram_pkg: shared types and constants for the DFFRAM request/response front end.
// Contents: response entry layout, default response-buffer depth, default RAM word
// address width and the byte-offset width of a 32-bit word address.
package dffram_pkg;

  // Default number of response-buffer entries (and outstanding-request credit).
  localparam int DEF_DEPTH = 3;

  // Default RAM word-address width (RAM depth is 2**DEF_AW words).
  localparam int DEF_AW = 12;

  // Byte-offset bits inside a 32-bit word; requests must have these bits clear.
  localparam int OFS_W = 2;

  // One buffered response: read data (zero for writes and errors) plus error flag.
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_entry_t;

  // True when a byte address cannot be served: misaligned, or beyond the RAM.
  function automatic logic addr_is_bad(input logic [31:0] addr, input int aw);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i < OFS_W) begin
        if (addr[i]) bad = 1'b1;
      end else if (i >= aw + OFS_W) begin
        if (addr[i]) bad = 1'b1;
      end
    end
    return bad;
  endfunction

endpackage

// File: rtl/dffram_rsp_fifo.sv
// dffram_rsp_fifo: DEPTH-entry synchronous FIFO of rsp_entry_t with occupancy count.
// Ports: clk/rst (async active-high), push + push_entry, pop, head (oldest entry),
//        count (number of valid entries). Push and pop may coincide when non-empty.
module dffram_rsp_fifo
  import dffram_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  rsp_entry_t    push_entry,
  input  logic          pop,
  output rsp_entry_t    head,
  output logic [CW-1:0] count
);

  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  rsp_entry_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Upstream credit keeps us from ever pushing into a full buffer; the guard
  // only stops a misbehaving caller from corrupting the oldest entry.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL_CNT) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (count == FULL_CNT) && !pop));

endmodule

// File: rtl/dffram_initiator.sv
// dffram_initiator: valid/ready front end that drives a single-port DFFRAM and returns
// in-order responses (rdata, err) two cycles after acceptance with rsp_ready held high.
// Ports: CLK/RST (async active-high); req_* request channel; rsp_* response channel;
//        ram_en/ram_we/ram_a/ram_di to the RAM, ram_do from the RAM (one cycle later).
module dffram_initiator
  import dffram_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [3:0]    req_be,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_a,
  output logic [31:0]   ram_di,
  input  logic [31:0]   ram_do
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic          run;        // low while in reset, high from the first edge after
  logic          fire;
  logic          req_err;
  logic          infl_vld;   // a request was accepted last cycle
  logic          infl_we;
  logic          infl_err;
  logic [CW-1:0] count;
  logic [CW:0]   used;
  logic          pop;
  rsp_entry_t    push_entry;
  rsp_entry_t    head;

  // Credit counts both buffered responses and the one still waiting for ram_do,
  // so every accepted request is guaranteed a buffer slot. rsp_ready is left out
  // on purpose: freed credit shows up only the cycle after the pop.
  assign used      = {1'b0, count} + {{CW{1'b0}}, infl_vld};
  assign req_ready = run && (used < DEPTH_W);
  assign fire      = req_valid && req_ready;
  assign req_err   = addr_is_bad(req_addr, AW);

  // The RAM is driven straight from the accepted request; errored requests never
  // touch it. A write with no byte enables still cycles the RAM as a no-op.
  assign ram_en = fire && !req_err;
  assign ram_we = (ram_en && req_we) ? req_be : 4'b0000;
  assign ram_a  = req_addr[AW+OFS_W-1:OFS_W];
  assign ram_di = req_wdata;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      run <= 1'b0;
    end else begin
      run <= 1'b1;
    end
  end

  // Errored requests still pass through this stage so responses stay in order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      infl_vld <= 1'b0;
      infl_we  <= 1'b0;
      infl_err <= 1'b0;
    end else begin
      infl_vld <= fire;
      if (fire) begin
        infl_we  <= req_we;
        infl_err <= req_err;
      end
    end
  end

  // ram_do is only meaningful for a successful read.
  always_comb begin
    push_entry.err   = infl_err;
    push_entry.rdata = (infl_err || infl_we) ? 32'h0 : ram_do;
  end

  assign pop = rsp_valid && rsp_ready;

  dffram_rsp_fifo #(
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk        (CLK),
    .rst        (RST),
    .push       (infl_vld),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

  // Head is masked so idle response outputs read as zero rather than stale data.
  assign rsp_valid = (count != '0);
  assign rsp_rdata = rsp_valid ? head.rdata : 32'h0;
  assign rsp_err   = rsp_valid && head.err;

  ram_only_on_good: assert property (@(posedge CLK) disable iff (RST)
    ram_en |-> (fire && !req_err));

endmodule

// File: tb/tb_dffram_initiator.sv
module tb_dffram_initiator;

  localparam int AW    = 12;
  localparam int DEPTH = 3;

  logic          CLK;
  logic          RST;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [3:0]    req_be;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_a;
  logic [31:0]   ram_di;
  logic [31:0]   ram_do;

  dffram_initiator #(.AW(AW), .DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_be    (req_be),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_a     (ram_a),
    .ram_di    (ram_di),
    .ram_do    (ram_do)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Environment: behavioural synchronous RAM (read data one cycle after EN).
  bit [31:0] ram_mem [4096];
  always @(posedge CLK) begin
    if (ram_en) begin
      ram_do <= ram_mem[ram_a];
      for (int b = 0; b < 4; b++) begin
        if (ram_we[b]) ram_mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
      end
    end
  end

  // Reference model: word memory updated at acceptance, queue of expected responses.
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  bit [31:0]   ref_mem [4096];
  exp_t        exp_q[$];
  int          nchk;
  int          nerr;
  int          cyc;
  int          n_acc;
  int          n_rsp;
  logic [31:0] last_rdata;
  bit          lat_chk;
  bit          rnd_rdy;
  bit          fired;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: observe handshakes at the negedge, then step past the posedge.
  task automatic tick();
    exp_t e;
    exp_t r;
    int   wi;
    @(negedge CLK);
    fired = 1'b0;
    if (RST) begin
      exp_q.delete();
    end else begin
      cyc++;
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          r = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, r.rdata);
          check("rsp_err", {31'd0, rsp_err}, {31'd0, r.err});
          if (lat_chk) check("rsp_latency", cyc - r.cyc, 32'd2);
          last_rdata = rsp_rdata;
        end
      end
      if (req_valid && req_ready) begin
        fired = 1'b1;
        n_acc++;
        e.cyc   = cyc;
        e.rdata = 32'h0;
        e.err   = ((req_addr % 4) != 0) || (req_addr >= 32'(4 << AW));
        if (e.err) begin
          check("ram_en_on_err", {31'd0, ram_en}, 32'd0);
        end else begin
          wi = int'(req_addr / 4);
          check("ram_en", {31'd0, ram_en}, 32'd1);
          check("ram_a", {20'd0, ram_a}, wi);
          check("ram_we", {28'd0, ram_we}, req_we ? {28'd0, req_be} : 32'd0);
          if (req_we) begin
            check("ram_di", ram_di, req_wdata);
            for (int b = 0; b < 4; b++) begin
              if (req_be[b]) ref_mem[wi][8*b +: 8] = req_wdata[8*b +: 8];
            end
          end else begin
            e.rdata = ref_mem[wi];
          end
        end
        exp_q.push_back(e);
      end else begin
        check("ram_idle", {31'd0, ram_en}, 32'd0);
      end
    end
    @(posedge CLK);
    #1;
    if (rnd_rdy) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wd);
    bit got;
    got       = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_be    = be;
    req_addr  = addr;
    req_wdata = wd;
    for (int t = 0; t < 40 && !got; t++) begin
      tick();
      got = fired;
    end
    req_valid = 1'b0;
    check("req_accept", {31'd0, got}, 32'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 80 && exp_q.size() > 0; t++) tick();
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd0);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    check({tag, "_ram_en"}, {31'd0, ram_en}, 32'd0);
    check({tag, "_ram_we"}, {28'd0, ram_we}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int r0;
    int c0;
    logic [31:0] addr;
    nchk = 0; nerr = 0; cyc = 0; n_acc = 0; n_rsp = 0;
    last_rdata = 32'h0; lat_chk = 1'b1; rnd_rdy = 1'b0; fired = 1'b0;
    RST = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;

    // Reset: a valid request presented during reset must not reach the RAM.
    #1 RST = 1'b1;
    req_valid = 1'b1; req_addr = 32'h10; req_we = 1'b1; req_be = 4'hF;
    #2;
    check_reset_outputs("rst0");
    req_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    tick();
    check("rst0_ready_after", {31'd0, req_ready}, 32'd1);

    // Basic write then read.
    send(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    send(1'b0, 4'h0, 32'h10, 32'h0);
    drain();
    check("t1_read", last_rdata, 32'hDEADBEEF);

    // Byte-enable merge.
    send(1'b1, 4'hF, 32'h20, 32'h11223344);
    send(1'b1, 4'b0100, 32'h20, 32'hAABBCCDD);
    send(1'b0, 4'h0, 32'h20, 32'h0);
    drain();
    check("t2_be_merge", last_rdata, 32'h11BB3344);

    // Error requests between valid reads; then a zero-enable write is a no-op.
    send(1'b0, 4'h0, 32'h10, 32'h0);
    send(1'b0, 4'h0, 32'h0000_0002, 32'h0);
    send(1'b0, 4'h0, 32'h0001_0000, 32'h0);
    send(1'b0, 4'h0, 32'h20, 32'h0);
    drain();
    check("t3_after_err", last_rdata, 32'h11BB3344);
    send(1'b1, 4'h0, 32'h20, 32'hFFFFFFFF);
    send(1'b0, 4'h0, 32'h20, 32'h0);
    drain();
    check("t3_be0_noop", last_rdata, 32'h11BB3344);

    // Backpressure: only DEPTH requests accepted while rsp_ready is low.
    lat_chk = 1'b0;
    rsp_ready = 1'b0;
    a0 = n_acc; r0 = n_rsp;
    send(1'b0, 4'h0, 32'h10, 32'h0);
    send(1'b0, 4'h0, 32'h20, 32'h0);
    send(1'b0, 4'h0, 32'h24, 32'h0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    repeat (5) tick();
    check("bp_accepted", n_acc - a0, 32'd3);
    check("bp_req_ready_low", {31'd0, req_ready}, 32'd0);
    check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("bp_no_comb_path", {31'd0, req_ready}, 32'd0);
    tick();
    check("bp_ready_rise", {31'd0, req_ready}, 32'd1);
    send(1'b0, 4'h0, 32'h10, 32'h0);
    send(1'b0, 4'h0, 32'h20, 32'h0);
    drain();
    check("bp_rsp_count", n_rsp - r0, 32'd5);
    lat_chk = 1'b1;

    // Back-to-back write/read of the same word, then sustained traffic.
    send(1'b1, 4'hF, 32'h40, 32'hCAFEF00D);
    send(1'b0, 4'h0, 32'h40, 32'h0);
    drain();
    check("t5_wr_rd", last_rdata, 32'hCAFEF00D);
    c0 = cyc;
    for (int i = 0; i < 20; i++) begin
      send(1'($urandom_range(0, 1)), 4'($urandom), 32'($urandom_range(0, 31)) * 4, $urandom);
    end
    check("t5_throughput", cyc - c0, 32'd20);
    drain();

    // Randomized traffic with random consumer stalls and idle gaps.
    lat_chk = 1'b0;
    rnd_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        tick();
      end else begin
        case ($urandom_range(0, 7))
          0:       addr = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(1, 3));
          1:       addr = ($urandom | 32'h4000) & 32'hFFFF_FFFC;
          default: addr = 32'($urandom_range(0, 31)) * 4;
        endcase
        send(1'($urandom_range(0, 1)), 4'($urandom), addr, $urandom);
      end
    end
    rnd_rdy = 1'b0;
    rsp_ready = 1'b1;
    drain();

    // Reset with two requests outstanding: both are dropped.
    rsp_ready = 1'b0;
    send(1'b0, 4'h0, 32'h10, 32'h0);
    send(1'b0, 4'h0, 32'h40, 32'h0);
    r0 = n_rsp;
    RST = 1'b1;
    #1;
    check_reset_outputs("rst1");
    tick();
    tick();
    RST = 1'b0;
    tick();
    check("rst1_ready_after", {31'd0, req_ready}, 32'd1);
    rsp_ready = 1'b1;
    repeat (6) tick();
    check("rst1_no_rsp", n_rsp - r0, 32'd0);
    check("rst1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    lat_chk = 1'b1;
    send(1'b1, 4'hF, 32'h44, 32'h5A5A1234);
    send(1'b0, 4'h0, 32'h44, 32'h0);
    drain();
    check("rst1_post_read", last_rdata, 32'h5A5A1234);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
